// File: rtl/cal_date_gen.sv
// Calendar date generator: month/day/two-digit year advanced by day_tick or loaded by set_en.
// Latency: one cycle; all outputs are registered and reflect the edge that sampled the request.
// Backpressure: none; every tick is accepted, and a set request in the same cycle discards the tick.
module cal_date_gen #(
  parameter int START_MONTH = 1,
  parameter int START_DAY   = 1,
  parameter int START_YEAR  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        day_tick,
  input  logic        set_en,
  input  logic [5:0]  set_month,
  input  logic [5:0]  set_day,
  input  logic [6:0]  set_year,
  output logic [11:0] rom_address,
  output logic [6:0]  year,
  output logic        month_wrap,
  output logic        year_wrap,
  output logic        set_err
);

  localparam logic [3:0] RST_MONTH = 4'(START_MONTH);
  localparam logic [4:0] RST_DAY   = 5'(START_DAY);
  localparam logic [6:0] RST_YEAR  = 7'(START_YEAR);

  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d;
  logic [6:0] year_q, year_d;
  logic       month_wrap_q, month_wrap_d;
  logic       year_wrap_q, year_wrap_d;
  logic       set_err_q, set_err_d;

  logic [4:0] cur_dim;
  logic [4:0] set_dim;
  logic       set_ok;

  // Days in month; leap years are those whose low two bits are zero (valid for 2000..2099).
  function automatic logic [4:0] dim_f(input logic [3:0] m, input logic leap);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = leap ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  // Next-state: set has priority over tick; a rejected set leaves the date untouched.
  always_comb begin
    month_d      = month_q;
    day_d        = day_q;
    year_d       = year_q;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;
    set_err_d    = 1'b0;

    cur_dim = dim_f(month_q, year_q[1:0] == 2'b00);
    set_dim = dim_f(set_month[3:0], set_year[1:0] == 2'b00);
    // Range-check the month before trusting set_dim, which only decodes the low nibble.
    set_ok  = (set_month >= 6'd1) && (set_month <= 6'd12) &&
              (set_year <= 7'd99) &&
              (set_day >= 6'd1) && (set_day <= {1'b0, set_dim});

    if (set_en) begin
      if (set_ok) begin
        month_d = set_month[3:0];
        day_d   = set_day[4:0];
        year_d  = set_year;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (day_tick) begin
      if (day_q < cur_dim) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d        = 5'd1;
        month_wrap_d = 1'b1;
        if (month_q == 4'd12) begin
          month_d     = 4'd1;
          year_wrap_d = 1'b1;
          year_d      = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end
  end

  // State and pulse registers; reset forces the start date asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      month_q      <= RST_MONTH;
      day_q        <= RST_DAY;
      year_q       <= RST_YEAR;
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
      set_err_q    <= 1'b0;
    end else begin
      month_q      <= month_d;
      day_q        <= day_d;
      year_q       <= year_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
      set_err_q    <= set_err_d;
    end
  end

  assign rom_address = {2'b00, month_q, 1'b0, day_q};
  assign year        = year_q;
  assign month_wrap  = month_wrap_q;
  assign year_wrap   = year_wrap_q;
  assign set_err     = set_err_q;

endmodule

// File: tb/tb_cal_date_gen.sv
// Randomized scoreboard bench for cal_date_gen against a calendar reference model.
// Latency: expected values are queued per driven cycle and checked one edge later.
// Backpressure: none; a monitor pops and compares every cycle the queue holds an entry.
module tb_cal_date_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        day_tick;
  logic        set_en;
  logic [5:0]  set_month;
  logic [5:0]  set_day;
  logic [6:0]  set_year;
  logic [11:0] rom_address;
  logic [6:0]  year;
  logic        month_wrap;
  logic        year_wrap;
  logic        set_err;

  cal_date_gen dut (
    .clk        (clk),
    .reset      (reset),
    .day_tick   (day_tick),
    .set_en     (set_en),
    .set_month  (set_month),
    .set_day    (set_day),
    .set_year   (set_year),
    .rom_address(rom_address),
    .year       (year),
    .month_wrap (month_wrap),
    .year_wrap  (year_wrap),
    .set_err    (set_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int d;
    int y;
    bit mw;
    bit yw;
    bit err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model state: a plain calendar date.
  int m_m = 1;
  int m_d = 1;
  int m_y = 0;
  int mdays [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int dim(int m, int y);
    if (m == 2 && (y % 4) == 0) return 29;
    return mdays[m-1];
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what the next rising edge must show.
  task automatic step(bit rst, bit tick, bit set, int sm, int sd, int sy);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    day_tick  = tick;
    set_en    = set;
    set_month = 6'(sm);
    set_day   = 6'(sd);
    set_year  = 7'(sy);
    e.mw = 0;
    e.yw = 0;
    e.err = 0;
    if (rst) begin
      m_m = 1; m_d = 1; m_y = 0;
    end else if (set) begin
      if (sm >= 1 && sm <= 12 && sy >= 0 && sy <= 99 && sd >= 1 && sd <= dim(sm, sy)) begin
        m_m = sm; m_d = sd; m_y = sy;
      end else begin
        e.err = 1;
      end
    end else if (tick) begin
      if (m_d < dim(m_m, m_y)) begin
        m_d = m_d + 1;
      end else begin
        m_d = 1;
        e.mw = 1;
        if (m_m == 12) begin
          m_m = 1;
          m_y = (m_y + 1) % 100;
          e.yw = 1;
        end else begin
          m_m = m_m + 1;
        end
      end
    end
    e.m = m_m;
    e.d = m_d;
    e.y = m_y;
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every output cycle with a queued expectation is compared.
  initial begin
    exp_t       e;
    logic [11:0] ea;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e  = q.pop_front();
        ea = 12'(e.m * 64 + e.d);
        tests++;
        if (rom_address !== ea || year !== 7'(e.y) || month_wrap !== e.mw ||
            year_wrap !== e.yw || set_err !== e.err) begin
          fails++;
          $display("FAIL cycle%0d: got addr=%h year=%0d mw=%b yw=%b err=%b, want addr=%h year=%0d mw=%b yw=%b err=%b",
                   cyc, rom_address, year, month_wrap, year_wrap, set_err,
                   ea, e.y, e.mw, e.yw, e.err);
        end
      end
    end
  end

  initial begin
    int r, sm, sd, sy;
    reset = 1'b1; day_tick = 1'b0; set_en = 1'b0;
    set_month = '0; set_day = '0; set_year = '0;

    // Reset state, with requests ignored while reset is high.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 3, 3, 3);
    #1;
    tests++;
    if (rom_address !== 12'h041 || year !== 7'd0 || month_wrap !== 1'b0 ||
        year_wrap !== 1'b0 || set_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: addr=%h year=%0d want 041/0", rom_address, year);
    end
    idle();

    // Month rollover from Jan 31.
    step(0, 0, 1, 1, 31, 5);
    step(0, 1, 0, 0, 0, 0);
    idle();
    // Leap and non-leap February.
    step(0, 0, 1, 2, 28, 4);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 2, 28, 5);
    step(0, 1, 0, 0, 0, 0);
    // Year rollover 99 -> 0.
    step(0, 0, 1, 12, 31, 99);
    step(0, 1, 0, 0, 0, 0);
    idle();
    // Rejected sets.
    step(0, 0, 1, 4, 31, 0);
    step(0, 0, 1, 2, 29, 3);
    idle();
    // Set wins over a simultaneous tick; also invalid set with tick.
    step(0, 1, 1, 3, 10, 20);
    step(0, 1, 1, 13, 10, 20);
    // Back-to-back ticks across a month boundary.
    step(0, 0, 1, 11, 28, 7);
    repeat (5) step(0, 1, 0, 0, 0, 0);
    idle();

    // Asynchronous reset from a non-start date.
    step(0, 0, 1, 7, 19, 42);
    step(1, 1, 0, 0, 0, 0);
    #1;
    tests++;
    if (rom_address !== 12'h041 || year !== 7'd0) begin
      fails++;
      $display("FAIL async_reset: addr=%h year=%0d want 041/0", rom_address, year);
    end
    idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if ($urandom_range(0, 1) == 1) begin
        sm = int'($urandom_range(1, 12));
        sy = int'($urandom_range(0, 99));
        sd = dim(sm, sy) - int'($urandom_range(0, 2)) + int'($urandom_range(0, 1));
      end else begin
        sm = int'($urandom_range(0, 15));
        sd = int'($urandom_range(0, 40));
        sy = int'($urandom_range(0, 127));
      end
      if (r < 4)        step(1, r[0], r[1], sm, sd, sy);
      else if (r < 150) step(0, r[0], 1, sm, sd, sy);
      else if (r < 800) step(0, 1, 0, sm, sd, sy);
      else              step(0, 0, 0, sm, sd, sy);
    end
    idle();

    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
